// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl
// Command sequencer for the SPI slave serial datapath. It counts bits of the
// incoming serial stream and decodes the command byte (READ/WRITE). It then
// assembles the address and drives a byte-wide memory port. Bursts
// auto-increment the address, which wraps silently at the top of the space.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   cs_n       chip select, active low, synchronous to clk
//   bit_stb    one-cycle strobe per serial bit (strobes >= 3 clk apart)
//   data_in    serial input bit, valid with bit_stb, MSB first
//   data_out   serial read bit (MSB of tx shift register), 0 outside RDATA
//   mem_addr   memory address
//   mem_wdata  write data
//   mem_we     one-cycle write pulse
//   mem_re     one-cycle read pulse
//   mem_rdata  read data, valid exactly one cycle after mem_re
//   cmd_err    one-cycle pulse on an unknown opcode
//   busy       high whenever the sequencer is not idle
module spi_cmd_ctrl #(
  parameter logic [7:0] command_read  = 8'b00000011,
  parameter logic [7:0] command_write = 8'b00000010,
  parameter int         addr_width    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs_n,
  input  logic                  bit_stb,
  input  logic                  data_in,
  output logic                  data_out,
  output logic [addr_width-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [7:0]            mem_rdata,
  output logic                  cmd_err,
  output logic                  busy
);

  // Counter is wide enough to count through the full address field.
  localparam int CW = $clog2(addr_width) + 1;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WDATA,
    RDATA,
    IGNORE
  } state_t;

  state_t                state, state_n;
  logic [CW-1:0]         bit_cnt, bit_cnt_n;
  logic [7:0]            rx, rx_n;
  logic [7:0]            tx, tx_n;
  logic                  rd_flag, rd_n;
  logic                  wr_flag, wr_n;
  logic                  load_pend, load_n;
  logic [addr_width-1:0] addr_n;
  logic [7:0]            wdata_n;
  logic                  we_n, re_n, err_n;

  // State and datapath registers. Everything is cleared by reset. The
  // load_pend flag marks the cycle in which mem_rdata answers the previous
  // mem_re.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      rx        <= '0;
      tx        <= '0;
      rd_flag   <= 1'b0;
      wr_flag   <= 1'b0;
      load_pend <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      rx        <= rx_n;
      tx        <= tx_n;
      rd_flag   <= rd_n;
      wr_flag   <= wr_n;
      load_pend <= load_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      mem_we    <= we_n;
      mem_re    <= re_n;
      cmd_err   <= err_n;
    end
  end

  // Next-state and datapath logic.
  // Accesses that were already issued (a mem_we pulse, or a read whose data
  // arrives this cycle) always finish their address increment, even if
  // cs_n has just risen. Deselect clears the framing state but leaves
  // mem_addr alone.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    rx_n      = rx;
    tx_n      = tx;
    rd_n      = rd_flag;
    wr_n      = wr_flag;
    load_n    = mem_re;
    addr_n    = mem_addr;
    wdata_n   = mem_wdata;
    we_n      = 1'b0;
    re_n      = 1'b0;
    err_n     = 1'b0;

    if (mem_we) begin
      addr_n = mem_addr + 1'b1;
    end
    if (load_pend) begin
      tx_n   = mem_rdata;
      addr_n = mem_addr + 1'b1;
    end

    if (cs_n) begin
      state_n   = IDLE;
      bit_cnt_n = '0;
      rx_n      = '0;
      tx_n      = '0;
      rd_n      = 1'b0;
      wr_n      = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_n   = CMD;
          bit_cnt_n = '0;
          rx_n      = '0;
        end

        CMD: begin
          if (bit_stb) begin
            rx_n = {rx[6:0], data_in};
            if (bit_cnt == CW'(7)) begin
              bit_cnt_n = '0;
              if (rx_n == command_read) begin
                state_n = ADDR;
                rd_n    = 1'b1;
              end else if (rx_n == command_write) begin
                state_n = ADDR;
                wr_n    = 1'b1;
              end else begin
                state_n = IGNORE;
                err_n   = 1'b1;
              end
            end else begin
              bit_cnt_n = bit_cnt + CW'(1);
            end
          end
        end

        // The first read is issued on entry to RDATA so that the byte is
        // ready before the host clocks its first read bit.
        ADDR: begin
          if (bit_stb) begin
            addr_n = {mem_addr[addr_width-2:0], data_in};
            if (bit_cnt == CW'(addr_width - 1)) begin
              bit_cnt_n = '0;
              if (rd_flag) begin
                state_n = RDATA;
                re_n    = 1'b1;
              end else if (wr_flag) begin
                state_n = WDATA;
              end else begin
                state_n = IGNORE;
              end
            end else begin
              bit_cnt_n = bit_cnt + CW'(1);
            end
          end
        end

        WDATA: begin
          if (bit_stb) begin
            rx_n = {rx[6:0], data_in};
            if (bit_cnt == CW'(7)) begin
              bit_cnt_n = '0;
              wdata_n   = rx_n;
              we_n      = 1'b1;
            end else begin
              bit_cnt_n = bit_cnt + CW'(1);
            end
          end
        end

        RDATA: begin
          if (bit_stb) begin
            tx_n = {tx[6:0], 1'b0};
            if (bit_cnt == CW'(7)) begin
              bit_cnt_n = '0;
              re_n      = 1'b1;
            end else begin
              bit_cnt_n = bit_cnt + CW'(1);
            end
          end
        end

        IGNORE: begin
          state_n = IGNORE;
        end

        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // While read data is arriving, its MSB is forwarded straight to data_out.
  // This lets the first bit appear one cycle before it lands in tx.
  assign data_out = (state == RDATA) && (load_pend ? mem_rdata[7] : tx[7]);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// tb_spi_cmd_ctrl
// Self-checking bench for spi_cmd_ctrl. A byte-wide memory model answers
// reads one cycle after mem_re and absorbs writes. Expected memory accesses
// and expected serial read bits are queued when a transaction is started.
// They are popped as the DUT produces them.
module tb_spi_cmd_ctrl;

  logic        clk;
  logic        rst;
  logic        cs_n;
  logic        bit_stb;
  logic        data_in;
  logic        data_out;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_rdata;
  logic        cmd_err;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int re_cnt = 0;
  int err_cnt = 0;

  logic [23:0] exp_we[$];
  logic [15:0] exp_re[$];
  logic        exp_bits[$];

  logic [7:0]  mem [0:65535];

  spi_cmd_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cs_n      (cs_n),
    .bit_stb   (bit_stb),
    .data_in   (data_in),
    .data_out  (data_out),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .cmd_err   (cmd_err),
    .busy      (busy)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: registered read data, one cycle after mem_re.
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory-port monitor: compares every access against the scoreboard.
  // Any extra pulse shows up in the per-test pulse counts.
  always @(negedge clk) begin
    logic [23:0] w;
    if (mem_we) begin
      we_cnt++;
      if (exp_we.size() > 0) begin
        w = exp_we.pop_front();
        checkOutput("we_addr", {16'h0, mem_addr}, {16'h0, w[23:8]});
        checkOutput("we_data", {24'h0, mem_wdata}, {24'h0, w[7:0]});
      end
    end
    if (mem_re) begin
      re_cnt++;
      if (exp_re.size() > 0) begin
        checkOutput("re_addr", {16'h0, mem_addr}, {16'h0, exp_re.pop_front()});
      end
    end
    if (cmd_err) err_cnt++;
  end

  task automatic strobeBit(input logic b);
    data_in = b;
    bit_stb = 1'b1;
    @(negedge clk);
    bit_stb = 1'b0;
    data_in = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) strobeBit(val[i]);
  endtask

  task automatic readBits(input int n);
    for (int i = 0; i < n; i++) begin
      if (exp_bits.size() > 0) checkOutput("data_out", {31'h0, data_out}, {31'h0, exp_bits.pop_front()});
      strobeBit(1'b0);
    end
  endtask

  task automatic pushByte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) exp_bits.push_back(b[i]);
  endtask

  task automatic selectChip();
    cs_n = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic deselect();
    cs_n = 1'b1;
    @(negedge clk);
    checkOutput("busy_after_cs", {31'h0, busy}, 32'h0);
  endtask

  task automatic doWrite(input logic [15:0] addr, input logic [7:0] data);
    int we0;
    we0 = we_cnt;
    exp_we.push_back({addr, data});
    selectChip();
    applyStimulus(32'h02, 8);
    applyStimulus({16'h0, addr}, 16);
    applyStimulus({24'h0, data}, 8);
    checkOutput("wr_addr_inc", {16'h0, mem_addr}, {16'h0, addr + 16'h1});
    checkOutput("wr_dout_zero", {31'h0, data_out}, 32'h0);
    checkOutput("wr_we_count", we_cnt - we0, 1);
    deselect();
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int we0, re0, e0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'hFFFF] = 8'h5A;
    mem[16'h0000] = 8'hC3;
    mem_rdata = 8'h00;
    rst = 1'b1;
    cs_n = 1'b1;
    bit_stb = 1'b0;
    data_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] reset values");
    checkOutput("rst_outputs", {16'h0, data_out, mem_we, mem_re, cmd_err, busy, 3'b0, mem_wdata}, 32'h0);
    checkOutput("rst_addr", {16'h0, mem_addr}, 32'h0);

    $display("[TB] reset during ADDR");
    selectChip();
    applyStimulus(32'h02, 8);
    applyStimulus(32'h12, 8);
    checkOutput("mid_addr_busy", {31'h0, busy}, 32'h1);
    checkOutput("mid_addr_value", {16'h0, mem_addr}, 32'h12);
    rst = 1'b1;
    cs_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_busy", {31'h0, busy}, 32'h0);
    checkOutput("rst_mid_addr", {16'h0, mem_addr}, 32'h0);
    checkOutput("rst_mid_outs", {27'h0, data_out, mem_we, mem_re, cmd_err, busy}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] single write");
    doWrite(16'h1234, 8'hA5);

    $display("[TB] burst read with wrap");
    re0 = re_cnt;
    exp_re.push_back(16'hFFFF);
    exp_re.push_back(16'h0000);
    exp_re.push_back(16'h0001);
    pushByte(8'h5A);
    pushByte(8'hC3);
    selectChip();
    applyStimulus(32'h03, 8);
    applyStimulus(32'hFFFF, 16);
    readBits(16);
    checkOutput("rd_addr_after", {16'h0, mem_addr}, 32'h2);
    checkOutput("rd_re_count", re_cnt - re0, 3);
    deselect();

    $display("[TB] unknown opcode");
    we0 = we_cnt; re0 = re_cnt; e0 = err_cnt;
    selectChip();
    applyStimulus(32'h9F, 8);
    applyStimulus(32'hABCDEF, 24);
    checkOutput("bad_busy", {31'h0, busy}, 32'h1);
    checkOutput("bad_dout", {31'h0, data_out}, 32'h0);
    checkOutput("bad_err_count", err_cnt - e0, 1);
    checkOutput("bad_mem_count", (we_cnt - we0) + (re_cnt - re0), 0);
    deselect();

    $display("[TB] abort partial write");
    we0 = we_cnt;
    selectChip();
    applyStimulus(32'h02, 8);
    applyStimulus(32'h0010, 16);
    applyStimulus(32'h15, 5);
    deselect();
    repeat (4) @(negedge clk);
    checkOutput("abort_we_count", we_cnt - we0, 0);
    checkOutput("abort_addr_hold", {16'h0, mem_addr}, 32'h10);

    $display("[TB] back-to-back write then read");
    doWrite(16'h0000, 8'h11);
    re0 = re_cnt;
    exp_re.push_back(16'h0000);
    exp_re.push_back(16'h0001);
    pushByte(8'h11);
    selectChip();
    applyStimulus(32'h03, 8);
    applyStimulus(32'h0000, 16);
    readBits(8);
    checkOutput("b2b_re_count", re_cnt - re0, 2);
    deselect();

    checkOutput("queues_drained", exp_we.size() + exp_re.size() + exp_bits.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
